dmi_dtm_initiator: RTL and testbench

- Debug-transport-side initiator for the 41-bit DMI request/response interface (7-bit address, 32-bit data, 2-bit op) that the debug module answers as responder.
- Converts TAP-domain dmi-register update/capture strobes into one outstanding DMI transaction and returns captured data plus the dmistat status.
- Sits between the JTAG TAP controller (strobes already in this clock domain) and the debug module DMI port.

---
 rtl/dmi_pkg.sv | 20 ++
 rtl/dmi_dtm_initiator_if.sv | 16 +
 rtl/dmi_timeout_ctr.sv | 18 +
 rtl/dmi_dtm_initiator.sv | 88 ++++++++
 tb/tb_dmi_dtm_initiator.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI encodings, FSM state and request/response types
package dmi_pkg;
    localparam int DMI_ABITS = 7;
    localparam logic [1:0] DMI_OP_NOP = 2'd0;
    localparam logic [1:0] DMI_OP_READ = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_RESP_OK = 2'd0;
    localparam logic [1:0] DMI_RESP_FAILED = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY = 2'd3;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} dmi_state_t;
    typedef struct packed {
        logic [DMI_ABITS-1:0] addr;
        logic [31:0] data;
        logic [1:0] op;
    } dmi_req_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0] resp;
    } dmi_resp_t;
endpackage

// File: rtl/dmi_dtm_initiator_if.sv
// dmi_dtm_initiator_if: DMI request/response channel between transport (master) and debug module (slave)
interface dmi_dtm_initiator_if import dmi_pkg::*; #(parameter int ABITS = DMI_ABITS);
    logic req_valid;
    logic req_ready;
    logic [ABITS-1:0] req_addr;
    logic [31:0] req_data;
    logic [1:0] req_op;
    logic resp_valid;
    logic resp_ready;
    logic [31:0] resp_data;
    logic [1:0] resp_resp;
    modport master(output req_valid, req_addr, req_data, req_op, resp_ready,
                   input req_ready, resp_valid, resp_data, resp_resp);
    modport slave(input req_valid, req_addr, req_data, req_op, resp_ready,
                  output req_ready, resp_valid, resp_data, resp_resp);
endinterface

// File: rtl/dmi_timeout_ctr.sv
// dmi_timeout_ctr: counts cycles while enabled and flags expiry on the LIMIT-th cycle
module dmi_timeout_ctr #(parameter int unsigned LIMIT = 1024) (
    input logic clock,
    input logic reset_n,
    input logic enable,
    input logic clear,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    assign expired = enable && count == W'(LIMIT - 1);
    // Count enabled cycles, restarting whenever cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable && !expired) count <= count + 1'b1;
    end
endmodule

// File: rtl/dmi_dtm_initiator.sv
// dmi_dtm_initiator: turns TAP dmi update/capture strobes into one outstanding DMI transaction; DMI_TIMEOUT_EN adds a response timeout
module dmi_dtm_initiator import dmi_pkg::*; #(
    parameter int ABITS = DMI_ABITS,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic clock,
    input logic reset_n,
    input logic upd_valid,
    input logic [ABITS-1:0] upd_addr,
    input logic [31:0] upd_data,
    input logic [1:0] upd_op,
    input logic cap_valid,
    output logic [ABITS-1:0] cap_addr,
    output logic [31:0] cap_data,
    output logic [1:0] cap_op,
    input logic dmireset,
    input logic dmihardreset,
    output logic busy,
    dmi_dtm_initiator_if.master dmi
);
    dmi_state_t state, nextState;
    logic [1:0] sticky, errCode;
    logic [ABITS-1:0] reqAddr;
    logic [31:0] reqData;
    logic [1:0] reqOp;
    logic accept, reqFire, respFire, violation, timeout;
    assign accept = upd_valid && (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE) && sticky == DMI_RESP_OK;
    assign reqFire = state == REQ && dmi.req_ready;
    assign respFire = state == WAIT && dmi.resp_valid;
    assign violation = state != IDLE && ((upd_valid && upd_op != DMI_OP_NOP) || cap_valid);
    assign errCode = (respFire && dmi.resp_resp != DMI_RESP_OK) ? dmi.resp_resp :
                     violation ? DMI_RESP_BUSY :
                     timeout ? DMI_RESP_FAILED : DMI_RESP_OK;
`ifdef DMI_TIMEOUT_EN
    dmi_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
        .clock(clock),
        .reset_n(reset_n),
        .enable(state == WAIT),
        .clear(state != WAIT),
        .expired(timeout)
    );
`else
    assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif
    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nextState;
    end
    // Next state: hard reset wins, then one transition per phase of the transaction
    always_comb begin
        nextState = dmihardreset ? IDLE :
                    (state == IDLE && accept) ? REQ :
                    reqFire ? WAIT :
                    (respFire || timeout) ? IDLE : state;
    end
    // Outputs decoded from state and the held request/status registers
    always_comb begin
        dmi.req_valid = state == REQ;
        dmi.resp_ready = state != REQ;
        dmi.req_addr = reqAddr;
        dmi.req_data = reqData;
        dmi.req_op = reqOp;
        busy = state != IDLE;
        cap_op = sticky;
    end
    // Request latch, capture registers and first-error-wins sticky status
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reqAddr <= '0;
            reqData <= '0;
            reqOp <= '0;
            cap_addr <= '0;
            cap_data <= '0;
            sticky <= DMI_RESP_OK;
        end else begin
            if (!dmihardreset && state == IDLE && accept) begin
                reqAddr <= upd_addr;
                reqData <= upd_data;
                reqOp <= upd_op;
            end
            if (!dmihardreset && reqFire) cap_addr <= reqAddr;
            if (!dmihardreset && respFire) cap_data <= dmi.resp_data;
            if (dmihardreset || dmireset) sticky <= DMI_RESP_OK;
            else if (sticky == DMI_RESP_OK) sticky <= errCode;
        end
    end
endmodule

// File: tb/tb_dmi_dtm_initiator.sv
// tb_dmi_dtm_initiator: directed self-checking bench for dmi_dtm_initiator
module tb_dmi_dtm_initiator;
    logic clock = 1'b0;
    logic reset_n;
    logic upd_valid, cap_valid, dmireset, dmihardreset, busy;
    logic [6:0] upd_addr, cap_addr;
    logic [31:0] upd_data, cap_data;
    logic [1:0] upd_op, cap_op;
    int nChecks = 0;
    int nFails = 0;

    dmi_dtm_initiator_if #(.ABITS(7)) dmi ();

    dmi_dtm_initiator #(.ABITS(7), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .upd_valid(upd_valid),
        .upd_addr(upd_addr),
        .upd_data(upd_data),
        .upd_op(upd_op),
        .cap_valid(cap_valid),
        .cap_addr(cap_addr),
        .cap_data(cap_data),
        .cap_op(cap_op),
        .dmireset(dmireset),
        .dmihardreset(dmihardreset),
        .busy(busy),
        .dmi(dmi.master)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        upd_valid = 1'b1;
        upd_op = op;
        upd_addr = addr;
        upd_data = data;
        step();
        upd_valid = 1'b0;
        upd_op = 2'd0;
    endtask

    task automatic respond(input logic [31:0] data, input logic [1:0] code);
        dmi.resp_valid = 1'b1;
        dmi.resp_data = data;
        dmi.resp_resp = code;
        step();
        dmi.resp_valid = 1'b0;
        dmi.resp_resp = 2'd0;
    endtask

    task automatic pulseDmireset();
        dmireset = 1'b1;
        step();
        dmireset = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        upd_valid = 1'b0; upd_addr = '0; upd_data = '0; upd_op = '0;
        cap_valid = 1'b0; dmireset = 1'b0; dmihardreset = 1'b0;
        dmi.req_ready = 1'b0; dmi.resp_valid = 1'b0; dmi.resp_data = '0; dmi.resp_resp = '0;
        step();
        step();
        chk("rst_req_valid", dmi.req_valid, 0);
        chk("rst_req_addr", dmi.req_addr, 0);
        chk("rst_resp_ready", dmi.resp_ready, 1);
        chk("rst_cap_addr", cap_addr, 0);
        chk("rst_cap_data", cap_data, 0);
        chk("rst_cap_op", cap_op, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        step();

        dmi.req_ready = 1'b1;
        upd(2'd2, 7'h10, 32'h8000_0001);
        chk("wr_req_valid", dmi.req_valid, 1);
        chk("wr_req_addr", dmi.req_addr, 'h10);
        chk("wr_req_data", dmi.req_data, 'h8000_0001);
        chk("wr_req_op", dmi.req_op, 2);
        chk("wr_busy", busy, 1);
        step();
        dmi.req_ready = 1'b0;
        chk("wr_req_valid_drop", dmi.req_valid, 0);
        chk("wr_cap_addr", cap_addr, 'h10);
        chk("wr_busy_wait", busy, 1);
        step();
        step();
        chk("wr_resp_ready", dmi.resp_ready, 1);
        respond(32'h11, 2'd0);
        chk("wr_busy_done", busy, 0);
        chk("wr_cap_op", cap_op, 0);
        chk("wr_cap_data", cap_data, 'h11);

        upd(2'd1, 7'h04, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_req_valid_hold", dmi.req_valid, 1);
            chk("rd_req_addr_hold", dmi.req_addr, 'h04);
            chk("rd_req_op_hold", dmi.req_op, 1);
            step();
        end
        dmi.req_ready = 1'b1;
        step();
        dmi.req_ready = 1'b0;
        chk("rd_cap_addr", cap_addr, 'h04);
        respond(32'hDEAD_BEEF, 2'd0);
        chk("rd_cap_data", cap_data, 'hDEAD_BEEF);
        chk("rd_cap_op", cap_op, 0);
        chk("rd_busy", busy, 0);

        dmi.req_ready = 1'b1;
        upd(2'd1, 7'h20, 32'h0);
        step();
        dmi.req_ready = 1'b0;
        upd(2'd1, 7'h21, 32'h0);
        chk("bv_cap_op", cap_op, 3);
        chk("bv_busy", busy, 1);
        chk("bv_no_second_req", dmi.req_valid, 0);
        respond(32'h55, 2'd0);
        chk("bv_cap_data", cap_data, 'h55);
        chk("bv_cap_op_kept", cap_op, 3);
        chk("bv_idle", busy, 0);
        upd(2'd2, 7'h30, 32'h5);
        chk("bv_blocked_valid", dmi.req_valid, 0);
        chk("bv_blocked_busy", busy, 0);
        pulseDmireset();
        chk("dmireset_clear", cap_op, 0);
        upd(2'd2, 7'h30, 32'h5);
        chk("after_reset_valid", dmi.req_valid, 1);
        chk("after_reset_addr", dmi.req_addr, 'h30);
        dmi.req_ready = 1'b1;
        step();
        dmi.req_ready = 1'b0;
        respond(32'h99, 2'd2);
        chk("fail_cap_op", cap_op, 2);
        chk("fail_cap_data", cap_data, 'h99);
        upd(2'd1, 7'h22, 32'h0);
        chk("fail_blocks_req", busy, 0);
        cap_valid = 1'b1;
        step();
        cap_valid = 1'b0;
        chk("fail_first_wins", cap_op, 2);

        pulseDmireset();
        upd(2'd1, 7'h08, 32'h0);
        cap_valid = 1'b1;
        dmireset = 1'b1;
        step();
        cap_valid = 1'b0;
        dmireset = 1'b0;
        chk("dmireset_priority", cap_op, 0);
        chk("dmireset_fsm_kept", dmi.req_valid, 1);
        cap_valid = 1'b1;
        step();
        cap_valid = 1'b0;
        chk("cap_in_req_violation", cap_op, 3);
        dmihardreset = 1'b1;
        step();
        dmihardreset = 1'b0;
        chk("hr_req_valid", dmi.req_valid, 0);
        chk("hr_busy", busy, 0);
        chk("hr_sticky", cap_op, 0);
        chk("hr_resp_ready", dmi.resp_ready, 1);
        respond(32'h1234, 2'd0);
        chk("hr_late_resp_drained", cap_data, 'h99);
        chk("hr_late_busy", busy, 0);

        upd(2'd3, 7'h01, 32'h1);
        chk("op3_ignored", busy, 0);
        dmi.req_ready = 1'b1;
        upd(2'd2, 7'h11, 32'hAB);
        step();
        dmi.req_ready = 1'b0;
        chk("sim_cap_addr", cap_addr, 'h11);
        upd_valid = 1'b1;
        upd_op = 2'd1;
        respond(32'h77, 2'd0);
        upd_valid = 1'b0;
        upd_op = 2'd0;
        chk("sim_cap_data", cap_data, 'h77);
        chk("sim_busy", busy, 0);
        chk("sim_cap_op", cap_op, 3);
        chk("sim_no_req", dmi.req_valid, 0);

`ifdef DMI_TIMEOUT_EN
        pulseDmireset();
        dmi.req_ready = 1'b1;
        upd(2'd1, 7'h05, 32'h0);
        step();
        dmi.req_ready = 1'b0;
        repeat (7) step();
        chk("to_still_wait", busy, 1);
        step();
        chk("to_idle", busy, 0);
        chk("to_cap_op", cap_op, 2);
        respond(32'h4321, 2'd0);
        chk("to_late_drained", cap_data, 'h77);
`endif

        pulseDmireset();
        upd(2'd1, 7'h06, 32'h0);
        chk("mid_req_valid", dmi.req_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("async_req_valid", dmi.req_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_cap_addr", cap_addr, 0);
        chk("async_cap_data", cap_data, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
